// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//
// Multi-channel debouncer for the front-panel switches and buttons. Each
// channel synchronises one asynchronous contact and applies a stable-time
// filter to it. The stable time is counted in ticks of a shared prescaler
// enable. Each channel produces a registered debounced level, a one-cycle
// press pulse and a one-cycle release pulse. When auto-repeat is enabled,
// a held button also produces repeat press pulses.
//
// Every channel carries its own debounce and repeat counters, so no
// external delay timer is needed. Channels share only clk, rst and tick.
//
// Parameters
//   N_CH        number of independent channels (1..32)
//   SYNC_STAGES synchroniser flops per channel (>= 2)
//   CNT_W       width of the per-channel counters
//   DELAY       consecutive stable ticks needed to accept a new level
//   REPEAT_EN   1 enables auto-repeat press pulses while a channel is held
//   HOLD        ticks spent held before the first repeat pulse
//   RATE        ticks between later repeat pulses
//
// Ports
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   sw     in   [N_CH] raw contact inputs, asynchronous, active-high
//   tick   in   count enable from the shared prescaler (tie high to count clk)
//   level  out  [N_CH] debounced level, registered
//   press  out  [N_CH] one-clk pulse on an accepted 0->1 edge and on each repeat
//   rel    out  [N_CH] one-clk pulse on an accepted 1->0 edge
//
// The release pulse output is named rel because "release" is a reserved
// word in SystemVerilog.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// debounce_channel
//
// One debouncer channel: a synchroniser chain followed by a four-state
// filter FSM with a debounce counter (dcnt) and a repeat counter (rcnt).
//
// Ports
//   clk, rst  clock and asynchronous active-high reset
//   sw        raw contact input
//   tick      count enable
//   level     debounced level (registered)
//   press     press / repeat pulse (registered)
//   rel       release pulse (registered)
// ---------------------------------------------------------------------------
module debounce_channel #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int DELAY       = 50000,
    parameter int REPEAT_EN   = 0,
    parameter int HOLD        = 40000,
    parameter int RATE        = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    input  logic tick,
    output logic level,
    output logic press,
    output logic rel
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD);

    // Reloading rcnt to HOLD-RATE after a repeat pulse means that the next
    // pulse comes RATE ticks later, using the same compare against HOLD.
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(HOLD - RATE);

    // With DELAY = 1, a changed level is accepted on the very first edge
    // that sees it. No wait state is spent in that case.
    localparam bit DELAY_ONE = (DELAY == 1);
    localparam bit REPEAT_ON = (REPEAT_EN != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] dcnt_inc, rcnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    // Synchroniser chain for the asynchronous contact. Bit 0 samples sw
    // first, and the top bit is the filtered input s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign dcnt_inc = dcnt_q + ONE_C;
    assign rcnt_inc = rcnt_q + ONE_C;

    // State, counters and registered outputs. Reset clears everything at
    // once, so a pulse in flight is dropped and no release is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Next-state logic. dcnt counts the ticks for which s has been stable
    // at the new value, including the tick on which the change is first
    // seen. This gives a press latency of SYNC_STAGES+DELAY-1 edges from
    // the first edge that samples the contact. Any bounce back to the old
    // value returns the FSM to its stable state and discards the count.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (s) begin
                    if (tick && DELAY_ONE) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        dcnt_d  = '0;
                        rcnt_d  = '0;
                    end else begin
                        state_d = PRESS_WAIT;
                        dcnt_d  = tick ? ONE_C : '0;
                    end
                end
            end

            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (tick) begin
                    if (dcnt_inc == DELAY_C) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        dcnt_d  = '0;
                        rcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_inc;
                    end
                end
            end

            // rcnt only advances while s is high in HELD. It keeps its value
            // through RELEASE_WAIT, so a bounce during release resumes the
            // repeat timing instead of restarting it.
            HELD: begin
                if (!s) begin
                    if (tick && DELAY_ONE) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        dcnt_d  = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        dcnt_d  = tick ? ONE_C : '0;
                    end
                end else if (REPEAT_ON && tick) begin
                    if (rcnt_inc == HOLD_C) begin
                        press_d = 1'b1;
                        rcnt_d  = RELOAD_C;
                    end else begin
                        rcnt_d = rcnt_inc;
                    end
                end
            end

            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                end else if (tick) begin
                    if (dcnt_inc == DELAY_C) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_inc;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

module debounce_bank #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int DELAY       = 50000,
    parameter int REPEAT_EN   = 0,
    parameter int HOLD        = 40000,
    parameter int RATE        = 10000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw,
    input  logic            tick,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] rel
);

    // The limit for DELAY, HOLD and RATE is computed in 64 bits so that the
    // check stays valid for CNT_W values up to 32.
    localparam longint CNT_LIMIT = longint'(1) << CNT_W;

    // Illegal parameter sets are rejected when the design is elaborated.
    // The counters never wrap, because every target fits in CNT_W bits.
    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
        $error("debounce_bank: N_CH must be in 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_bank: SYNC_STAGES must be at least 2");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cntw
        $error("debounce_bank: CNT_W must be in 1..32");
    end
    if (DELAY < 1 || longint'(DELAY) >= CNT_LIMIT) begin : g_bad_delay
        $error("debounce_bank: DELAY must be in 1..2^CNT_W-1");
    end
    if (HOLD < 1 || longint'(HOLD) >= CNT_LIMIT) begin : g_bad_hold
        $error("debounce_bank: HOLD must be in 1..2^CNT_W-1");
    end
    if (RATE < 1 || longint'(RATE) >= CNT_LIMIT) begin : g_bad_rate
        $error("debounce_bank: RATE must be in 1..2^CNT_W-1");
    end
    // The repeat reload value HOLD-RATE must not be negative.
    if (REPEAT_EN != 0 && RATE > HOLD) begin : g_bad_repeat
        $error("debounce_bank: RATE must not exceed HOLD when REPEAT_EN=1");
    end

    // One fully independent channel per contact.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .DELAY       (DELAY),
            .REPEAT_EN   (REPEAT_EN),
            .HOLD        (HOLD),
            .RATE        (RATE)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .sw    (sw[i]),
            .tick  (tick),
            .level (level[i]),
            .press (press[i]),
            .rel   (rel[i])
        );
    end

endmodule
